// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, FSM state type and clear-count constant for the register file
package regfile_pkg;
  localparam int DW = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int CLR_CNT = NREG - 1;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
endpackage

// File: rtl/regfile_onehot_wr_onehot_check.sv
// onehot_check: flags an input with exactly one bit set
module onehot_check
  import regfile_pkg::*;
#(
  parameter int N = NREG
) (
  input  logic [N-1:0] sel,
  output logic         is_onehot
);
  assign is_onehot = (sel != '0) && ((sel & (sel - N'(1))) == '0);
endmodule

// File: rtl/regfile_onehot_wr.sv
// regfile_onehot_wr: one-hot-write register file with bypassed registered reads and sequential clear
module regfile_onehot_wr
  import regfile_pkg::*;
#(
  parameter int DW = regfile_pkg::DW,
  parameter int NREG = regfile_pkg::NREG,
  parameter int AW = regfile_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [NREG-1:0] wr_sel,
  input  logic [DW-1:0]   wr_data,
  input  logic [AW-1:0]   rd_addr0,
  input  logic [AW-1:0]   rd_addr1,
  output logic [DW-1:0]   rd_data0,
  output logic [DW-1:0]   rd_data1,
  input  logic            clr_req,
  output logic            busy,
  output logic            err
);
  state_t state, state_nxt;
  logic [AW-1:0] cnt;
  logic [NREG-1:0] stg_sel;
  logic [DW-1:0] stg_data;
  logic [DW-1:0] regs [NREG];
  logic sel_ok, accept, clr_go, take;
  logic [DW-1:0] rd_nxt0, rd_nxt1;

  onehot_check #(.N(NREG)) u_chk (.sel(wr_sel), .is_onehot(sel_ok));

  assign wr_ready = state == ST_IDLE;
  assign busy = state == ST_CLEAR;
  assign accept = wr_valid && wr_ready;
  assign clr_go = clr_req && wr_ready;
  assign take = accept && sel_ok && !clr_go;

  always_comb begin
    state_nxt = clr_go ? ST_CLEAR : (busy && cnt == AW'(CLR_CNT)) ? ST_IDLE : state;
    rd_nxt0 = (rd_addr0 == '0 || (busy && cnt == rd_addr0)) ? '0 : stg_sel[rd_addr0] ? stg_data : regs[rd_addr0];
    rd_nxt1 = (rd_addr1 == '0 || (busy && cnt == rd_addr1)) ? '0 : stg_sel[rd_addr1] ? stg_data : regs[rd_addr1];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nxt;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      stg_sel <= '0;
      stg_data <= '0;
      err <= 1'b0;
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else begin
      cnt <= clr_go ? AW'(1) : busy ? cnt + AW'(1) : cnt;
      stg_sel <= take ? wr_sel : '0;
      stg_data <= wr_data;
      err <= clr_go ? 1'b0 : (accept && !sel_ok) ? 1'b1 : err;
      rd_data0 <= rd_nxt0;
      rd_data1 <= rd_nxt1;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (busy && cnt == AW'(i)) regs[i] <= '0;
        else if (stg_sel[i]) regs[i] <= stg_data;
    end
endmodule

// File: tb/tb_regfile_onehot_wr.sv
// tb_regfile_onehot_wr: table-driven and directed checks of the one-hot-write register file
module tb_regfile_onehot_wr;
  logic clk = 1'b0, rst = 1'b1;
  logic wr_valid = 1'b0, wr_ready, clr_req = 1'b0, busy, err;
  logic [31:0] wr_sel = '0, wr_data = '0, rd_data0, rd_data1;
  logic [4:0] rd_addr0 = '0, rd_addr1 = '0;
  int checks = 0, errors = 0;

  typedef struct {
    logic        wv;
    logic [31:0] sel;
    logic [31:0] data;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eerr;
  } vec_t;
  vec_t tbl [11];

  regfile_onehot_wr dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_data(wr_data), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0),
    .rd_data1(rd_data1), .clr_req(clr_req), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] sel, input logic [31:0] data,
                       input logic [4:0] a0, input logic [4:0] a1, input logic clr);
    wr_valid = wv;
    wr_sel = sel;
    wr_data = data;
    rd_addr0 = a0;
    rd_addr1 = a1;
    clr_req = clr;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h20, 32'hDEADBEEF, 5'd5, 5'd0, 32'h0, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'h10, 32'h44444444, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0, 32'h0, 5'd4, 5'd5, 32'h44444444, 32'hDEADBEEF, 1'b0};
    tbl[5]  = '{1'b1, 32'h1, 32'hFFFFFFFF, 5'd4, 5'd0, 32'h44444444, 32'h0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0, 32'h0, 5'd4, 5'd5, 32'h44444444, 32'hDEADBEEF, 1'b0};
    tbl[8]  = '{1'b1, 32'h30, 32'h12345678, 5'd4, 5'd5, 32'h44444444, 32'hDEADBEEF, 1'b1};
    tbl[9]  = '{1'b0, 32'h0, 32'h0, 5'd4, 5'd5, 32'h44444444, 32'hDEADBEEF, 1'b1};
    tbl[10] = '{1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b1};

    step();
    step();
    rst = 1'b0;
    chk("reset rd_data0", rd_data0, 32'h0);
    chk("reset rd_data1", rd_data1, 32'h0);
    chk("reset err", err, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset wr_ready", wr_ready, 1'b1);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].wv, tbl[i].sel, tbl[i].data, tbl[i].a0, tbl[i].a1, 1'b0);
      step();
      chk($sformatf("vec%0d rd_data0", i), rd_data0, tbl[i].e0);
      chk($sformatf("vec%0d rd_data1", i), rd_data1, tbl[i].e1);
      chk($sformatf("vec%0d err", i), err, tbl[i].eerr);
    end

    drive(1'b1, 32'h2, 32'h11111111, 5'd0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h0002_0000, 32'h17171717, 5'd0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h8000_0000, 32'h31313131, 5'd0, 5'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 5'd17, 5'd31, 1'b0);
    step();
    chk("pre-clear r17", rd_data0, 32'h17171717);
    chk("pre-clear r31", rd_data1, 32'h31313131);
    drive(1'b0, 32'h0, 32'h0, 5'd17, 5'd31, 1'b1);
    step();
    chk("clr edge busy", busy, 1'b1);
    chk("clr edge wr_ready", wr_ready, 1'b0);
    chk("clr edge err", err, 1'b0);
    chk("clr edge r17", rd_data0, 32'h17171717);
    clr_req = 1'b0;
    for (int r = 1; r <= 31; r++) begin
      rd_addr1 = (r == 1) ? 5'd1 : 5'd31;
      step();
      chk($sformatf("clr c+%0d busy", r), busy, (r < 31) ? 1'b1 : 1'b0);
      chk($sformatf("clr c+%0d wr_ready", r), wr_ready, (r == 31) ? 1'b1 : 1'b0);
      chk($sformatf("clr c+%0d r17", r), rd_data0, (r < 17) ? 32'h17171717 : 32'h0);
      if (r > 1) chk($sformatf("clr c+%0d r31", r), rd_data1, (r < 31) ? 32'h31313131 : 32'h0);
      else chk("clr c+1 r1", rd_data1, 32'h0);
    end
    for (int a = 1; a < 32; a++) begin
      drive(1'b0, 32'h0, 32'h0, 5'(a), 5'(32 - a), 1'b0);
      step();
      chk($sformatf("post-clear r%0d", a), rd_data0 | rd_data1, 32'h0);
    end

    drive(1'b1, 32'h0010_0000, 32'h20202020, 5'd0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h4000_0000, 32'h30303030, 5'd0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h0, 32'h99999999, 5'd0, 5'd0, 1'b0);
    step();
    chk("zero sel err", err, 1'b1);
    drive(1'b1, 32'h8, 32'h33333333, 5'd3, 5'd2, 1'b0);
    step();
    drive(1'b1, 32'h4, 32'hAAAAAAAA, 5'd3, 5'd2, 1'b1);
    step();
    chk("clr+wr busy", busy, 1'b1);
    chk("clr+wr err", err, 1'b0);
    chk("clr+wr commit bypass r3", rd_data0, 32'h33333333);
    drive(1'b0, 32'h0, 32'h0, 5'd3, 5'd2, 1'b0);
    for (int r = 1; r <= 10; r++) begin
      step();
      chk($sformatf("clr2 c+%0d r3", r), rd_data0, (r < 3) ? 32'h33333333 : 32'h0);
      chk($sformatf("clr2 c+%0d r2 dropped", r), rd_data1, 32'h0);
      chk($sformatf("clr2 c+%0d busy", r), busy, 1'b1);
    end
    #4;
    rst = 1'b1;
    #1;
    chk("mid-clear rst busy", busy, 1'b0);
    chk("mid-clear rst wr_ready", wr_ready, 1'b1);
    chk("mid-clear rst err", err, 1'b0);
    chk("mid-clear rst rd_data0", rd_data0, 32'h0);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd20, 5'd30, 1'b0);
    step();
    chk("after rst r20", rd_data0, 32'h0);
    chk("after rst r30", rd_data1, 32'h0);
    drive(1'b1, 32'h8, 32'h55555555, 5'd3, 5'd3, 1'b0);
    step();
    chk("after rst wr accept ready", wr_ready, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 1'b0);
    step();
    chk("after rst r3 bypass", rd_data0, 32'h55555555);
    step();
    chk("after rst r3 hold", rd_data1, 32'h55555555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_onehot_wr.md
# regfile_onehot_wr

Register file for the RegisterFile datapath: 32 × 32-bit registers with a one-hot write select, two registered read ports, write-to-read bypass and a sequential clear engine. It sits directly downstream of the one-hot select stage, which feeds `wr_sel`. Register 0 is hardwired to zero.

## Interface
Parameters:
- `DW`, 32: data width.
- `NREG`, 32: register count; equals the width of `wr_sel`.
- `AW`, 5: read address width, log2(`NREG`).

Ports:
- `clk`, in, 1: the block's single clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `wr_valid`, in, 1: write request.
- `wr_ready`, out, 1: block can accept a write.
- `wr_sel`, in, `NREG`: one-hot target register.
- `wr_data`, in, `DW`: write data.
- `rd_addr0`, `rd_addr1`, in, `AW`: binary read addresses.
- `rd_data0`, `rd_data1`, out, `DW`: registered read data.
- `clr_req`, in, 1: clear-all request, one-cycle pulse.
- `busy`, out, 1: clear in progress.
- `err`, out, 1: sticky flag for a non-one-hot select.

## Operation
- FSM states:
  - IDLE: `wr_ready`=1, `busy`=0.
  - CLEAR: `wr_ready`=0, `busy`=1.
- Write handshake: a write is accepted at a clock edge where `wr_valid`&`wr_ready`=1. `wr_sel`/`wr_data` are captured into a one-entry stage register. The write commits to the array at the next edge. The stage register drains every cycle, so IDLE never back-pressures.
- Select check at acceptance: `wr_sel` with popcount≠1 (zero or multiple bits) means the write is dropped and `err` is set. `err` stays set until reset or until `clr_req` is accepted.
- `wr_sel`=1 (register 0) is accepted and has no effect. It is not an error.
- Reads: `rd_addrN` is sampled every edge; `rd_dataN` updates at that edge.
  - If a commit to the same register happens at that edge, the read returns the committing data (bypass).
  - Address 0 always returns 0.
- Clear: `clr_req` is accepted in IDLE. Accepting it clears `err` and enters CLEAR.
  - A 5-bit counter clears registers 1..31, one per edge, over 31 edges, then returns to IDLE.
  - `clr_req` is ignored while in CLEAR.
- Simultaneous events:
  - A write committing at the `clr_req` edge commits normally.
  - A write accepted at the same edge as `clr_req` is dropped, because clear has priority.
  - A read of the register being cleared at an edge returns 0.
- Reset, including mid-CLEAR: all registers=0, stage register empty, state IDLE, `err`=0, `rd_data0`/`rd_data1`=0, `wr_ready`=1, `busy`=0.

## Timing
- Write accepted at edge k, committed at edge k+1.
- A read sampled at edge k returns the old value.
- Reads sampled at edge k+1 (bypass) and later return the new value.
- Read latency is 1 cycle from address to `rd_dataN`.
- `err` rises at edge k for a bad select.
- Clear:
  - `clr_req` is sampled at edge c.
  - `busy` is high from edge c through c+31 inclusive.
  - Register r (1..31) is cleared at edge c+r.
  - IDLE and `wr_ready`=1 resume after edge c+31.

## Structure
- Shared package `regfile_pkg`: `DW`, `NREG`, `AW` defaults; state enum {`ST_IDLE`, `ST_CLEAR`}; clear-count constant `NREG-1`.
- Sub-module `onehot_check`: combinational `NREG`-bit input, `is_onehot` output (popcount==1). The same function serves the upstream stage's bench.
- The top level holds the FSM, the clear counter, the stage register, the array and the read bypass.

## Test plan
- Reset, then write `wr_sel`=32'h0000_0020, `wr_data`=32'hDEADBEEF at edge k, with `rd_addr0`=5 → `rd_data0`=0 after edge k, 32'hDEADBEEF after edge k+1 (bypass), and it holds afterwards.
- `wr_sel`=32'h0000_0030, `wr_data`=32'h1234_5678 → `err`=1 after the edge; registers 4 and 5 are unchanged.
- `wr_sel`=0 → `err`=1.
- `wr_sel`=32'h1, `wr_data`=32'hFFFF_FFFF → `rd_data1`@addr 0 =0 and `err`=0.
- Write registers 1, 17 and 31 with nonzero data, then pulse `clr_req` at edge c:
  - `busy`=1 and `wr_ready`=0 for 31 cycles;
  - `err` is cleared;
  - register 17 reads 0 from edge c+17;
  - all registers read 0 after c+31.
- `wr_valid` with `clr_req` at the same edge → that write is dropped, and register 2 reads 0 after the clear.
- Assert `rst` at clear step 10 → `busy`=0 and `wr_ready`=1 immediately; all registers read 0; a new write to register 3 succeeds.
